// File: rtl/draw_circle_pkg.sv
// Shared gfx definitions for the circle drawer.
// Holds the FSM state encoding and the per-pair quadrant count.
package draw_circle_pkg;

  localparam int STATEW = 3;
  localparam int QUADS  = 4;

  typedef enum logic [STATEW-1:0] {
    IDLE       = 3'd0,
    INIT       = 3'd1,
    WAIT_VALID = 3'd2,
    PLOT       = 3'd3,
    ACK        = 3'd4,
    WAIT_NEXT  = 3'd5,
    DONE       = 3'd6
  } state_t;

endpackage

// File: rtl/draw_circle_circle.sv
// Circle distance generator (bresenham/midpoint octant walk).
// Emits (xa, ya) pairs from xa = -r up to xa = 0; each pair is held until oe.
module circle #(
  parameter int CORDW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    oe,
  input  logic signed [CORDW-1:0] r0,
  output logic signed [CORDW-1:0] xa,
  output logic signed [CORDW-1:0] ya,
  output logic                    valid,
  output logic                    done
);

  // Error term needs headroom beyond the coordinate width for 2*r style terms.
  localparam int ERRW = CORDW + 2;
  localparam logic signed [ERRW-1:0]  ERR_ONE   = ERRW'(1);
  localparam logic signed [ERRW-1:0]  ERR_TWO   = ERRW'(2);
  localparam logic signed [ERRW-1:0]  ERR_THREE = ERRW'(3);
  localparam logic signed [CORDW-1:0] C_ONE     = CORDW'(1);

  logic signed [ERRW-1:0]  err;
  logic signed [ERRW-1:0]  err_y;
  logic signed [ERRW-1:0]  err_next;
  logic signed [ERRW-1:0]  x_ext;
  logic signed [ERRW-1:0]  y_ext;
  logic signed [ERRW-1:0]  y_new_ext;
  logic signed [ERRW-1:0]  r_ext;
  logic signed [CORDW-1:0] y_new;
  logic                    step_y;
  logic                    step_x;

  always_comb begin
    x_ext     = {{2{xa[CORDW-1]}}, xa};
    y_ext     = {{2{ya[CORDW-1]}}, ya};
    r_ext     = {{2{r0[CORDW-1]}}, r0};
    step_y    = (err <= y_ext);
    y_new     = step_y ? (ya + C_ONE) : ya;
    y_new_ext = {{2{y_new[CORDW-1]}}, y_new};
    err_y     = step_y ? (err + (y_new_ext <<< 1) + ERR_ONE) : err;
    // x test uses the pre-step error and the post-step error against the new y
    step_x    = (err > x_ext) || (err_y > y_new_ext);
    err_next  = step_x ? (err_y + (x_ext <<< 1) + ERR_THREE) : err_y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xa    <= '0;
      ya    <= '0;
      err   <= '0;
      valid <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        xa    <= -r0;
        ya    <= '0;
        err   <= ERR_TWO - (r_ext <<< 1);
        valid <= 1'b1;
      end else if (oe && valid) begin
        if (xa == '0) begin
          valid <= 1'b0;
          done  <= 1'b1;
        end else begin
          ya  <= y_new;
          err <= err_next;
          if (step_x) xa <= xa + C_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/draw_circle.sv
// Circle drawer: walks the distance generator and emits four symmetric pixels
// per generated pair, with a valid/accept (drawing/oe) handshake on x/y.
//
// state      | meaning
// IDLE       | waiting for start; centre and radius latched on acceptance
// INIT       | one-cycle start pulse to the generator
// WAIT_VALID | waiting for the first generator pair
// PLOT       | presenting the four quadrant pixels of the current pair
// ACK        | one-cycle oe pulse to the generator to advance
// WAIT_NEXT  | waiting for the next pair or generator completion
// DONE       | one-cycle done pulse
module draw_circle
  import draw_circle_pkg::*;
#(
  parameter int CORDW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    oe,
  input  logic signed [CORDW-1:0] cx,
  input  logic signed [CORDW-1:0] cy,
  input  logic signed [CORDW-1:0] r,
  output logic signed [CORDW-1:0] x,
  output logic signed [CORDW-1:0] y,
  output logic                    busy,
  output logic                    drawing,
  output logic                    done
);

  state_t state;
  state_t state_next;

  logic [1:0]              quad;
  logic [1:0]              quad_load;
  logic                    load_px;
  logic signed [CORDW-1:0] cx_l;
  logic signed [CORDW-1:0] cy_l;
  logic signed [CORDW-1:0] r_l;
  logic signed [CORDW-1:0] px;
  logic signed [CORDW-1:0] py;

  logic                    gen_start;
  logic                    gen_oe;
  logic signed [CORDW-1:0] gen_xa;
  logic signed [CORDW-1:0] gen_ya;
  logic                    gen_valid;
  logic                    gen_done;

  circle #(
    .CORDW(CORDW)
  ) u_circle (
    .clk   (clk),
    .rst   (rst),
    .start (gen_start),
    .oe    (gen_oe),
    .r0    (r_l),
    .xa    (gen_xa),
    .ya    (gen_ya),
    .valid (gen_valid),
    .done  (gen_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    gen_start  = 1'b0;
    gen_oe     = 1'b0;
    load_px    = 1'b0;
    quad_load  = quad + 2'd1;
    case (state)
      IDLE: begin
        // a negative radius has nothing to draw, so skip the generator entirely
        if (start) state_next = r[CORDW-1] ? DONE : INIT;
      end
      INIT: begin
        gen_start  = 1'b1;
        state_next = WAIT_VALID;
      end
      WAIT_VALID: begin
        if (gen_valid) begin
          load_px    = 1'b1;
          quad_load  = 2'd0;
          state_next = PLOT;
        end
      end
      PLOT: begin
        if (oe) begin
          if (quad == 2'(QUADS - 1)) state_next = ACK;
          else                       load_px    = 1'b1;
        end
      end
      ACK: begin
        gen_oe     = 1'b1;
        state_next = WAIT_NEXT;
      end
      WAIT_NEXT: begin
        if (gen_done) begin
          state_next = DONE;
        end else if (gen_valid) begin
          load_px    = 1'b1;
          quad_load  = 2'd0;
          state_next = PLOT;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    px = cx_l - gen_xa;
    py = cy_l + gen_ya;
    case (quad_load)
      2'd1: begin
        px = cx_l - gen_ya;
        py = cy_l - gen_xa;
      end
      2'd2: begin
        px = cx_l + gen_xa;
        py = cy_l - gen_ya;
      end
      2'd3: begin
        px = cx_l + gen_ya;
        py = cy_l + gen_xa;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cx_l <= '0;
      cy_l <= '0;
      r_l  <= '0;
      quad <= '0;
      x    <= '0;
      y    <= '0;
    end else begin
      if (state == IDLE && start) begin
        cx_l <= cx;
        cy_l <= cy;
        r_l  <= r;
      end
      if (load_px) begin
        x    <= px;
        y    <= py;
        quad <= quad_load;
      end
    end
  end

  assign busy    = (state != IDLE) && (state != DONE);
  assign drawing = (state == PLOT);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_draw_circle.sv
// Scoreboard bench for draw_circle: directed circles with hand-computed pixels,
// checked by a negedge monitor that pops one entry per pixel transfer or done pulse.
module tb_draw_circle;

  localparam int CORDW = 16;
  typedef logic signed [CORDW-1:0] coord_t;
  typedef struct packed {
    logic   is_done;
    coord_t ex;
    coord_t ey;
  } exp_t;

  logic   clk   = 1'b0;
  logic   rst   = 1'b1;
  logic   start = 1'b0;
  logic   oe    = 1'b1;
  coord_t cx    = '0;
  coord_t cy    = '0;
  coord_t r     = '0;
  coord_t x;
  coord_t y;
  logic   busy;
  logic   drawing;
  logic   done;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pix = 0;

  draw_circle #(.CORDW(CORDW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .oe      (oe),
    .cx      (cx),
    .cy      (cy),
    .r       (r),
    .x       (x),
    .y       (y),
    .busy    (busy),
    .drawing (drawing),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // monitor: every transfer (drawing & oe) and every done cycle consumes one entry
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (drawing && oe) begin
        n_pix++;
        n_cmp++;
        if (sb.size() == 0 || sb[0].is_done) begin
          n_err++;
          $display("FAIL pixel: got (%0d,%0d), required no pixel", x, y);
        end else begin
          e = sb.pop_front();
          if (x !== e.ex || y !== e.ey) begin
            n_err++;
            $display("FAIL pixel: got (%0d,%0d), required (%0d,%0d)", x, y, e.ex, e.ey);
          end
        end
      end
      if (done) begin
        n_cmp++;
        if (sb.size() == 0 || !sb[0].is_done) begin
          n_err++;
          $display("FAIL done: got done=1, required 0 (%0d entries pending)", sb.size());
        end else begin
          e = sb.pop_front();
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic push_pix(input int px, input int py);
    exp_t e;
    e.is_done = 1'b0;
    e.ex = coord_t'(px);
    e.ey = coord_t'(py);
    sb.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.ex = '0;
    e.ey = '0;
    sb.push_back(e);
  endtask

  task automatic push_pair(input int ccx, input int ccy, input int xa, input int ya);
    push_pix(ccx - xa, ccy + ya);
    push_pix(ccx - ya, ccy - xa);
    push_pix(ccx + xa, ccy - ya);
    push_pix(ccx + ya, ccy + xa);
  endtask

  task automatic push_r1_origin();
    push_pix(1, 0);  push_pix(0, 1);  push_pix(-1, 0); push_pix(0, -1);
    push_pix(0, 1);  push_pix(-1, 0); push_pix(0, -1); push_pix(1, 0);
    push_done();
  endtask

  // returns one tick after the edge that samples start
  task automatic start_draw(input int ccx, input int ccy, input int rr);
    @(posedge clk);
    #1;
    cx    = coord_t'(ccx);
    cy    = coord_t'(ccy);
    r     = coord_t'(rr);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int k;
    k = 0;
    while (sb.size() != 0 && k < max_cycles) begin
      @(posedge clk);
      k++;
    end
    check({name, "_drained"}, sb.size(), 0);
    sb.delete();
    #1;
    check({name, "_busy_after"}, int'(busy), 0);
  endtask

  task automatic wait_pixels(input int target);
    int g;
    g = 0;
    while (n_pix < target && g < 500) begin
      @(posedge clk);
      g++;
    end
    check("pixel_wait", int'(n_pix >= target), 1);
  endtask

  initial begin
    int lat;
    int base;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_drawing", int'(drawing), 0);
    check("rst_done", int'(done), 0);
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);

    // start on the same edge as rst must be lost
    start = 1'b1;
    r     = 16'sd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b0;
    check("rst_wins_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    check("rst_wins_still_idle", int'(busy), 0);

    // r = 0: four pixels at the centre, then done
    repeat (4) push_pix(10, 20);
    push_done();
    start_draw(10, 20, 0);
    check("busy_rises", int'(busy), 1);
    lat = 0;
    while (!drawing && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("first_pixel_latency_le4", int'(lat <= 4), 1);
    wait_drain("r0", 200);

    // r = 1 around the origin, oe held high
    push_r1_origin();
    start_draw(0, 0, 1);
    wait_drain("r1", 200);

    // r = 1 with oe low for 5 cycles while the first pixel is shown
    oe = 1'b0;
    push_r1_origin();
    start_draw(0, 0, 1);
    lat = 0;
    while (!drawing && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_x", int'(x), 1);
      check("stall_y", int'(y), 0);
      check("stall_drawing", int'(drawing), 1);
      @(posedge clk);
      #1;
    end
    oe = 1'b1;
    wait_drain("r1_stall", 200);

    // start with r=5 mid-draw must be ignored
    base = n_pix;
    push_r1_origin();
    start_draw(0, 0, 1);
    wait_pixels(base + 3);
    #1;
    cx    = 16'sd7;
    r     = 16'sd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain("r1_restart_ignored", 200);

    // coordinate sums wrap at CORDW bits
    push_pix(-32768, 0); push_pix(32767, 1); push_pix(32766, 0); push_pix(32767, -1);
    push_pix(32767, 1);  push_pix(32766, 0); push_pix(32767, -1); push_pix(-32768, 0);
    push_done();
    start_draw(32767, 0, 1);
    wait_drain("wrap", 200);

    // reset after the 3rd pixel of an r=4 draw
    base = n_pix;
    push_pix(4, 0); push_pix(0, 4); push_pix(-4, 0);
    start_draw(0, 0, 4);
    wait_pixels(base + 3);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_drawing", int'(drawing), 0);
    check("abort_done", int'(done), 0);
    check("abort_queue_empty", sb.size(), 0);
    rst = 1'b0;

    // full r=4 circle at (3,-2); generator pairs worked by hand
    push_pair(3, -2, -4, 0);
    push_pair(3, -2, -4, 1);
    push_pair(3, -2, -3, 2);
    push_pair(3, -2, -2, 3);
    push_pair(3, -2, -1, 4);
    push_pair(3, -2,  0, 4);
    push_done();
    start_draw(3, -2, 4);
    wait_drain("r4_full", 1000);

    // negative radius: no pixels, done within 2 cycles
    base = n_pix;
    push_done();
    start_draw(5, 5, -3);
    lat = 0;
    while (!done && lat < 5) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("neg_r_done_within_2", int'(lat <= 2), 1);
    wait_drain("neg_r", 20);
    check("neg_r_no_pixels", n_pix - base, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/draw_circle.md
DRAW_CIRCLE -- requirements
Module: draw_circle

Interface
REQ-001 The block SHALL have parameter CORDW, default 16, meaning signed coordinate width.
REQ-002 The block SHALL have port clk, input, 1 bit, the clock.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset: synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin drawing a circle.
REQ-005 The block SHALL have port oe, input, 1 bit, the downstream pixel-accept (output enable).
REQ-006 The block SHALL have ports cx and cy, input, CORDW signed, the circle centre.
REQ-007 The block SHALL have port r, input, CORDW signed, the radius.
REQ-008 The block SHALL have ports x and y, output, CORDW signed, the pixel coordinate presented.
REQ-009 The block SHALL have port busy, output, 1 bit, high while drawing is in progress.
REQ-010 The block SHALL have port drawing, output, 1 bit, high while x/y hold a valid pixel.
REQ-011 The block SHALL have port done, output, 1 bit, a one-cycle pulse when the circle is complete.

Function
REQ-012 The block SHALL act as the consumer of the circle distance generator: it drives that generator's start/oe/r0 and consumes its xa/ya/valid/done.
REQ-013 start SHALL be accepted only in IDLE; cx, cy and r SHALL be latched on acceptance, and busy SHALL rise on the next edge.
REQ-014 start asserted while busy SHALL be ignored, and the latched values SHALL be unchanged.
REQ-015 States: IDLE, INIT, WAIT_VALID, PLOT, ACK, WAIT_NEXT, DONE.
- INIT: one-cycle generator start pulse.
- WAIT_VALID: wait for generator valid.
- PLOT: emit quadrants.
- ACK: one-cycle generator oe pulse.
- WAIT_NEXT: wait for generator valid (go to PLOT) or generator done (go to DONE).
- DONE: done pulse, return to IDLE.
REQ-016 For each generator (xa, ya) pair, where xa ranges from -r to 0, PLOT SHALL present exactly four pixels in this order, using a 2-bit quadrant counter:
- (cx-xa, cy+ya)
- (cx-ya, cy-xa)
- (cx+xa, cy-ya)
- (cx+ya, cy+xa)
REQ-017 A pixel SHALL be transferred on any edge where drawing and oe are both high; x, y and drawing SHALL hold unchanged while oe is low.
REQ-018 After the fourth pixel of a pair transfers, the block SHALL enter ACK and pulse the generator's oe for exactly one cycle; drawing SHALL be low in ACK and WAIT_NEXT.
REQ-019 The first pixel SHALL be presented (drawing high) no later than the 4th clock edge after start is sampled.
REQ-020 done SHALL pulse high for exactly one cycle, after the final pixel has transferred and the generator's done has been seen; busy SHALL fall on the same edge that raises done.
REQ-021 r = 0 SHALL produce four pixels, all at (cx, cy), followed by done.
REQ-022 r < 0 SHALL produce no pixels; done SHALL pulse within 2 cycles of acceptance, and the generator SHALL NOT be started.
REQ-023 Coordinate sums SHALL be computed at CORDW width and wrap modulo 2^CORDW, with no saturation.
REQ-024 x and y SHALL be registered outputs.

Reset
REQ-025 On rst, state SHALL become IDLE and outputs SHALL be busy=0, drawing=0, done=0, x=0, y=0.
REQ-026 rst asserted mid-operation SHALL abort the drawing without asserting done, and the generator SHALL also be reset by rst.
REQ-027 If rst and start are asserted on the same edge, rst SHALL win.

Structure
REQ-028 The FSM state encoding (STATEW=3) and quadrant count constant (4) SHALL reside in the shared gfx package.
REQ-029 The block SHALL instantiate exactly one sub-module, circle (the distance generator), with CORDW passed through.

Verification
REQ-030 Stimulus: cx=10, cy=20, r=0, start, oe held high. Required response: four pixels at (10,20), then a single done pulse, then busy=0.
REQ-031 Stimulus: cx=0, cy=0, r=1, oe held high. Required response: eight pixels in order (1,0), (0,1), (-1,0), (0,-1), (0,1), (-1,0), (0,-1), (1,0), then done.
REQ-032 Stimulus: r=1, with oe low for 5 cycles while the first pixel is presented. Required response: x=1, y=0 and drawing=1 stable for all 5 cycles; the sequence then resumes unchanged.
REQ-033 Stimulus: start pulsed mid-draw with r=5. Required response: ignored; the original r=1 sequence completes as in REQ-031.
REQ-034 Stimulus: rst after the 3rd pixel of an r=4 draw. Required response: the next cycle shows busy=0, drawing=0, done=0; a new start then draws the full circle correctly.
REQ-035 Stimulus: r=-3. Required response: zero pixels, with done pulsing within 2 cycles of acceptance.
